// File: rtl/cmd_uart_tx.sv
// Command-queue UART transmitter: buffers {instr, addr} commands and sends each one
// as 2 or 4 back-to-back 8N1 frames, instruction low byte first.
module cmd_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CMD_DEPTH    = 4,
  parameter int ADDRESS_SIZE = 9,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [15:0]                    cmd_instr,
  input  logic [ADDRESS_SIZE-1:0]        cmd_addr,
  output logic                           tx,
  output logic                           busy,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic                           halt_sent
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(CMD_DEPTH);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [3:0]              BIT_D7   = 4'd8;
  localparam logic [3:0]              BIT_STOP = 4'd9;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [15:0]             hold_instr_reg, hold_instr_next;
  logic [ADDRESS_SIZE-1:0] hold_addr_reg, hold_addr_next;
  logic [1:0]              byte_idx_reg, byte_idx_next;
  logic [1:0]              byte_last_reg, byte_last_next;
  logic [3:0]              bit_cnt_reg, bit_cnt_next;
  logic [TMR_W-1:0]        timer_reg, timer_next;
  logic                    tx_reg, tx_next;
  logic                    halt_reg, halt_next;

  logic [15:0]             mem_instr [CMD_DEPTH];
  logic [ADDRESS_SIZE-1:0] mem_addr  [CMD_DEPTH];

  logic                    push, pop, bit_end, frame_end, cmd_end;
  logic                    head_long, cur_halt;
  logic [15:0]             head_instr, addr_ext;
  logic [ADDRESS_SIZE-1:0] head_addr;
  logic [7:0]              cur_byte;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_reg] <= cmd_instr;
      mem_addr[wr_ptr_reg]  <= cmd_addr;
    end
  end

  // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_comb begin
    push       = cmd_valid && cmd_ready;
    bit_end    = (timer_reg == TMR_LAST);
    frame_end  = (state_reg == ST_SEND) && bit_end && (bit_cnt_reg == BIT_STOP);
    cmd_end    = frame_end && (byte_idx_reg == byte_last_reg);
    pop        = (count_reg != '0) && ((state_reg == ST_IDLE) || cmd_end);
    head_instr = mem_instr[rd_ptr_reg];
    head_addr  = mem_addr[rd_ptr_reg];
    head_long  = (head_instr[OPCODE_WIDTH-1:0] == OP_STORE) && head_instr[4];
    cur_halt   = (hold_instr_reg[OPCODE_WIDTH-1:0] == OP_HALT);
    addr_ext   = 16'(hold_addr_reg);
    case (byte_idx_reg)
      2'd0:    cur_byte = hold_instr_reg[7:0];
      2'd1:    cur_byte = hold_instr_reg[15:8];
      2'd2:    cur_byte = addr_ext[7:0];
      default: cur_byte = addr_ext[15:8];
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    hold_instr_next = hold_instr_reg;
    hold_addr_next  = hold_addr_reg;
    byte_idx_next   = byte_idx_reg;
    byte_last_next  = byte_last_reg;
    bit_cnt_next    = bit_cnt_reg;
    timer_next      = timer_reg;
    tx_next         = tx_reg;
    halt_next       = 1'b0;

    case (state_reg)
      ST_SEND: begin
        timer_next = timer_reg + TMR_W'(1);
        if (bit_end) begin
          timer_next = '0;
          if (bit_cnt_reg != BIT_STOP) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            tx_next      = (bit_cnt_reg == BIT_D7) ? 1'b1 : cur_byte[bit_cnt_reg[2:0]];
          end else if (!cmd_end) begin
            byte_idx_next = byte_idx_reg + 2'd1;
            bit_cnt_next  = '0;
            tx_next       = 1'b0;
          end else begin
            halt_next  = cur_halt;
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A pop always starts byte 0 of the popped command, so the start bit
    // follows the previous stop bit (or idle) with no gap.
    if (pop) begin
      hold_instr_next = head_instr;
      hold_addr_next  = head_addr;
      byte_last_next  = head_long ? 2'd3 : 2'd1;
      byte_idx_next   = '0;
      bit_cnt_next    = '0;
      timer_next      = '0;
      tx_next         = 1'b0;
      state_next      = ST_SEND;
      rd_ptr_next     = rd_ptr_reg + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      hold_instr_reg <= '0;
      hold_addr_reg  <= '0;
      byte_idx_reg   <= '0;
      byte_last_reg  <= '0;
      bit_cnt_reg    <= '0;
      timer_reg      <= '0;
      tx_reg         <= 1'b1;
      halt_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      hold_instr_reg <= hold_instr_next;
      hold_addr_reg  <= hold_addr_next;
      byte_idx_reg   <= byte_idx_next;
      byte_last_reg  <= byte_last_next;
      bit_cnt_reg    <= bit_cnt_next;
      timer_reg      <= timer_next;
      tx_reg         <= tx_next;
      halt_reg       <= halt_next;
    end
  end

  assign cmd_ready = (count_reg < CNT_FULL);
  assign cmd_count = count_reg;
  assign busy      = (count_reg != '0) || (state_reg != ST_IDLE);
  assign tx        = tx_reg;
  assign halt_sent = halt_reg;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Bench for cmd_uart_tx: a UART line decoder compares every received byte with a
// byte-list model of the accepted commands, plus table vectors and corner sequences.
module tb_cmd_uart_tx;
  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int AS       = 9;
  localparam int CLK_NS   = 10;
  localparam int FRAME_NS = 10 * CPB * CLK_NS;

  logic          clk, rst_n, cmd_valid, cmd_ready, tx, busy, halt_sent;
  logic [15:0]   cmd_instr;
  logic [AS-1:0] cmd_addr;
  logic [2:0]    cmd_count;

  cmd_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CMD_DEPTH   (DEPTH),
    .ADDRESS_SIZE(AS),
    .OPCODE_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr),
    .cmd_addr (cmd_addr),
    .tx       (tx),
    .busy     (busy),
    .cmd_count(cmd_count),
    .halt_sent(halt_sent)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Reference model: the byte list each accepted command must produce on the line
  logic [7:0] exp_q[$];
  int         exp_halts;

  function automatic int cmd_len(input int instr);
    return ((instr % 8) == 0 && ((instr / 16) % 2) == 1) ? 4 : 2;
  endfunction

  task automatic model_push(input int instr, input int addr);
    exp_q.push_back(8'(instr % 256));
    exp_q.push_back(8'(instr / 256));
    if (cmd_len(instr) == 4) begin
      exp_q.push_back(8'(addr % 256));
      exp_q.push_back(8'(addr / 256));
    end
    if ((instr % 8) == 4) exp_halts++;
  endtask

  // Line decoder: detects start bits, samples mid-bit, records byte and start time
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_active;
  int         rx_cnt, rx_t0;
  logic [9:0] rx_bits;

  initial begin
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_t0     = 0;
    rx_bits   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_t0     = int'($time) - CLK_NS / 2;
        end
        if (rx_active) begin
          if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] = tx;
          if (rx_cnt == 9 * CPB + CPB / 2) begin
            rx_active = 1'b0;
            check_bit("stop_bit", rx_bits[9], 1'b1);
            rx_q.push_back(rx_bits[8:1]);
            rx_t.push_back(rx_t0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got byte %02h, model expected no frame", rx_bits[8:1]);
            end else begin
              logic [7:0] e_byte;
              e_byte = exp_q.pop_front();
              check_byte("line_byte", rx_bits[8:1], e_byte);
            end
          end
          rx_cnt++;
        end
      end
    end
  end

  // Output event monitor
  int   halt_cycles, halt_rise_t, busy_fall_t;
  logic busy_prev, halt_prev;

  initial begin
    halt_cycles = 0;
    halt_rise_t = -1;
    busy_fall_t = -1;
    busy_prev   = 1'b0;
    halt_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_t = int'($time) - CLK_NS / 2;
      if (halt_sent === 1'b1) begin
        halt_cycles++;
        if (halt_prev !== 1'b1) halt_rise_t = int'($time) - CLK_NS / 2;
      end
      busy_prev = busy;
      halt_prev = halt_sent;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic [15:0] instr, input logic [AS-1:0] addr, output int t_acc);
    int waited;
    waited    = 0;
    t_acc     = -1;
    cmd_instr = instr;
    cmd_addr  = addr;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
    end else begin
      @(posedge clk);
      t_acc = int'($time);
      model_push(int'(instr), int'(addr));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || rx_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0 || rx_active) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0]   instr;
    logic [AS-1:0] addr;
    int            nbytes;
    logic [31:0]   bytes_le;
    logic          is_halt;
  } vec_t;

  vec_t vecs[8];
  int   t_acc, t_acc2, bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0A3A, 9'h000, 2, 32'h0000_0A3A, 1'b0};  // RUN
    vecs[1] = '{16'h0010, 9'h1A5, 4, 32'h01A5_0010, 1'b0};  // STORE with address
    vecs[2] = '{16'h0008, 9'h0FF, 2, 32'h0000_0008, 1'b0};  // STORE without address
    vecs[3] = '{16'h0004, 9'h000, 2, 32'h0000_0004, 1'b1};  // HALT
    vecs[4] = '{16'h8011, 9'h123, 2, 32'h0000_8011, 1'b0};  // FETCH with bit4 set
    vecs[5] = '{16'hFFF7, 9'h1FF, 2, 32'h0000_FFF7, 1'b0};  // opcode 7
    vecs[6] = '{16'hFF10, 9'h0C3, 4, 32'h00C3_FF10, 1'b0};  // STORE, high addr byte 0
    vecs[7] = '{16'h1234, 9'h1FF, 2, 32'h0000_1234, 1'b1};  // HALT with bit4 set

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_instr = '0;
    cmd_addr  = '0;
    exp_halts = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_tx", tx, 1'b1);
    check_bit("rst_ready", cmd_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_int("rst_count", int'(cmd_count), 0);
    check_bit("rst_halt", halt_sent, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    check_int("idle_100_bad_cycles", bad, 0);

    // Table vectors, one command at a time
    for (int i = 0; i < 8; i++) begin
      rx_q.delete();
      rx_t.delete();
      halt_cycles = 0;
      halt_rise_t = -1;
      busy_fall_t = -1;
      send_cmd(vecs[i].instr, vecs[i].addr, t_acc);
      cmd_valid = 1'b0;
      check_bit($sformatf("v%0d_busy", i), busy, 1'b1);
      wait_idle();
      check_int($sformatf("v%0d_nframes", i), rx_q.size(), vecs[i].nbytes);
      for (int j = 0; j < vecs[i].nbytes && j < rx_q.size(); j++) begin
        check_byte($sformatf("v%0d_byte%0d", i, j), rx_q[j], vecs[i].bytes_le[8*j +: 8]);
        if (j > 0) check_int($sformatf("v%0d_gap%0d", i, j), rx_t[j] - rx_t[j-1], FRAME_NS);
      end
      if (rx_t.size() > 0) check_int($sformatf("v%0d_start_delay", i), rx_t[0] - t_acc, CLK_NS);
      check_int($sformatf("v%0d_busy_fall", i), busy_fall_t - t_acc, CLK_NS + vecs[i].nbytes * FRAME_NS);
      check_int($sformatf("v%0d_halt_cycles", i), halt_cycles, vecs[i].is_halt ? 1 : 0);
      if (vecs[i].is_halt) check_int($sformatf("v%0d_halt_edge", i), halt_rise_t, busy_fall_t);
    end

    // Queue full: six commands with cmd_valid held high
    rx_q.delete();
    rx_t.delete();
    send_cmd(16'h1111, 9'h000, t_acc);
    check_int("qf_count1", int'(cmd_count), 1);
    send_cmd(16'h2222, 9'h000, t_acc2);
    check_int("qf_count2", int'(cmd_count), 1);
    send_cmd(16'h3333, 9'h000, t_acc2);
    send_cmd(16'h4445, 9'h000, t_acc2);
    send_cmd(16'h0010, 9'h0AB, t_acc2);
    check_int("qf_count_full", int'(cmd_count), 4);
    check_bit("qf_ready_low", cmd_ready, 1'b0);
    send_cmd(16'h5556, 9'h000, t_acc2);
    cmd_valid = 1'b0;
    wait_idle();
    check_int("qf_nframes", rx_q.size(), 14);
    bad = 0;
    for (int j = 1; j < rx_t.size(); j++) if (rx_t[j] - rx_t[j-1] != FRAME_NS) bad++;
    check_int("qf_gapped_frames", bad, 0);
    if (rx_t.size() > 0) check_int("qf_start_delay", rx_t[0] - t_acc, CLK_NS);

    // Reset during data bit 3 of the first frame, one command still queued
    rx_q.delete();
    rx_t.delete();
    send_cmd(16'h0A32, 9'h000, t_acc);
    send_cmd(16'h0505, 9'h000, t_acc2);
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);
    check_int("mid_pre_count", int'(cmd_count), 1);
    check_bit("mid_pre_tx_bit3", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_bit("mid_rst_tx", tx, 1'b1);
    check_int("mid_rst_count", int'(cmd_count), 0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_ready", cmd_ready, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_int("mid_no_resume", rx_q.size(), 0);
    send_cmd(16'h0A32, 9'h000, t_acc);
    cmd_valid = 1'b0;
    wait_idle();
    check_int("mid_fresh_nframes", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check_byte("mid_fresh_b0", rx_q[0], 8'h32);
      check_byte("mid_fresh_b1", rx_q[1], 8'h0A);
      check_int("mid_fresh_delay", rx_t[0] - t_acc, CLK_NS);
    end

    // Randomized commands with random gaps against the byte-list model
    halt_cycles = 0;
    exp_halts   = 0;
    for (int i = 0; i < 25; i++) begin
      logic [15:0]   r_instr;
      logic [AS-1:0] r_addr;
      r_instr = 16'($urandom);
      r_addr  = AS'($urandom);
      if ($urandom_range(0, 3) == 0) r_instr[4:0] = 5'b10000;
      else if ($urandom_range(0, 4) == 0) r_instr[2:0] = 3'd4;
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_cmd(r_instr, r_addr, t_acc);
    end
    cmd_valid = 1'b0;
    wait_idle();
    check_int("rand_model_drained", exp_q.size(), 0);
    check_int("rand_halt_pulses", halt_cycles, exp_halts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
